// File: rtl/pio_multi_commit_if.sv
// Avalon-MM slave bus plus the committed-vector valid/ready handshake
// of the multi-channel output port, bundled as one interface.
interface pio_multi_commit_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 20,
    parameter int ADDR_W   = 4
) ();
    logic [ADDR_W-1:0]         address;
    logic                      chipselect;
    logic                      write_n;
    logic [31:0]               writedata;
    logic [31:0]               readdata;
    logic [CHANNELS*WIDTH-1:0] out_port;
    logic                      out_valid;
    logic                      out_ready;

    // Host/downstream side: drives the bus and the ready line.
    modport master (
        output address, chipselect, write_n, writedata, out_ready,
        input  readdata, out_port, out_valid
    );

    // Port side: decodes the bus and presents the live vector.
    modport slave (
        input  address, chipselect, write_n, writedata, out_ready,
        output readdata, out_port, out_valid
    );
endinterface

// File: rtl/pio_multi_commit.sv
// Multi-channel output PIO with shadow registers and an atomic commit.
// The host fills shadow[], then one commit copies every channel to the
// live outputs at once and holds out_valid until downstream takes it.
module pio_multi_commit #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 20,
    parameter int ADDR_W      = 4,
    parameter int AUTO_COMMIT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    pio_multi_commit_if.slave bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [31:0] CTRL_ADDR = 32'(CHANNELS);
    localparam logic [31:0] STAT_ADDR = 32'(CHANNELS + 1);
    localparam logic [31:0] LIVE_BASE = 32'(CHANNELS + 2);
    localparam logic [31:0] LAST_CH   = 32'(CHANNELS - 1);

    logic [WIDTH-1:0] shadow_q [CHANNELS];
    logic [WIDTH-1:0] shadow_d [CHANNELS];
    logic [WIDTH-1:0] live_q   [CHANNELS];
    logic [WIDTH-1:0] live_d   [CHANNELS];
    state_t           state_q, state_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      count_q, count_d;

    logic [31:0] addr32;
    logic        wr;
    logic        ctrl_wr;
    logic        commit_req;
    logic        commit_ok;
    logic        ovf_set;
    logic        ovf_clr;
    logic [31:0] rd;

    // Bus decode: write strobe, commit request and whether it can be taken.
    always_comb begin
        addr32     = 32'(bus.address);
        wr         = bus.chipselect && !bus.write_n;
        ctrl_wr    = wr && (addr32 == CTRL_ADDR);
        commit_req = (ctrl_wr && bus.writedata[0]) ||
                     ((AUTO_COMMIT != 0) && wr && (addr32 == LAST_CH));
        // A pending vector may be replaced only on the edge it is consumed.
        commit_ok  = commit_req && ((state_q == IDLE) || bus.out_ready);
        ovf_set    = commit_req && (state_q == PENDING) && !bus.out_ready;
        ovf_clr    = ctrl_wr && bus.writedata[1];
    end

    // Next-state for shadow/live registers, counter, overflow and FSM.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr && (addr32 == 32'(i))) begin
                shadow_d[i] = bus.writedata[WIDTH-1:0];
            end
        end

        // Copy from shadow_d so an auto-commit captures the word being
        // written to the last channel in the same cycle.
        for (int i = 0; i < CHANNELS; i++) begin
            live_d[i] = commit_ok ? shadow_d[i] : live_q[i];
        end

        count_d = commit_ok ? count_q + 16'd1 : count_q;

        // Set has priority over a simultaneous clear.
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (commit_ok) state_d = PENDING;
            PENDING: if (commit_ok)          state_d = PENDING;
                     else if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous clear of everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                live_q[i]   <= '0;
            end
            state_q    <= IDLE;
            overflow_q <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                live_q[i]   <= live_d[i];
            end
            state_q    <= state_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    // Combinational read mux; unmapped and CTRL addresses read zero.
    always_comb begin
        rd = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (addr32 == 32'(i)) begin
                rd[WIDTH-1:0] = shadow_q[i];
            end
            if (addr32 == LIVE_BASE + 32'(i)) begin
                rd[WIDTH-1:0] = live_q[i];
            end
        end
        if (addr32 == STAT_ADDR) begin
            rd = {count_q, 14'd0, overflow_q, state_q == PENDING};
        end
        bus.readdata = rd;
    end

    // Live vector and handshake outputs, straight from the flops.
    always_comb begin
        bus.out_port = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.out_port[i*WIDTH +: WIDTH] = live_q[i];
        end
        bus.out_valid = (state_q == PENDING);
    end

endmodule

// File: doc/pio_multi_commit.md
# pio_multi_commit

Parametrised multi-channel Avalon-MM output port with double-buffered channel registers and an atomic commit. The HPS writes all channel values into shadow registers, then a single commit copies them to the live outputs together and raises a valid/ready handshake. This lets the neural-network datapath sample a coherent input vector. The block replaces the single-register output PIOs on the lightweight HPS bridge.

## Interface
Parameters:
- CHANNELS, 4, number of output channels (1–16)
- WIDTH, 20, bits per channel (1–32)
- ADDR_W, 4, word-address width; must satisfy 2^ADDR_W >= 2*CHANNELS+2
- AUTO_COMMIT, 0, when 1 a write to shadow channel CHANNELS-1 also issues a commit

Ports:
- clk  in  1  sole clock; all logic rising-edge
- reset_n  in  1  reset, asynchronous and active-low
- address  in  ADDR_W  Avalon-MM word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address
- out_port  out  CHANNELS*WIDTH  live channel values, channel i at bits [i*WIDTH +: WIDTH]
- out_valid  out  1  committed vector available
- out_ready  in  1  downstream accepts vector

## Operation
- Write = chipselect && !write_n, on a rising clk edge.
- Address map:
  - 0..CHANNELS-1: shadow[i], R/W, low WIDTH bits
  - CHANNELS: CTRL, write-only, reads 0; bit0 = commit, bit1 = clear overflow
  - CHANNELS+1: STATUS, RO; bit0 = out_valid, bit1 = overflow, bits[31:16] = commit_count
  - CHANNELS+2..2*CHANNELS+1: live[i], RO
  - Any other address reads 0; writes to it are ignored.
- readdata is zero-extended above WIDTH.
- Commit request sources: a CTRL write with bit0=1, or, when AUTO_COMMIT=1, a write to shadow[CHANNELS-1].
  - An auto-commit latches the value being written in that same cycle into live[CHANNELS-1].
- States:
  - IDLE: out_valid=0.
  - PENDING: out_valid=1.
- Transitions:
  - IDLE + commit: all live <= shadow, commit_count += 1, go to PENDING.
  - PENDING + out_ready, no commit: go to IDLE; live holds its value.
  - PENDING + out_ready + commit: the transfer completes and the new commit is accepted. live updates, count increments, and the block stays in PENDING.
  - PENDING + commit without out_ready: the commit is dropped. live and count are unchanged, and overflow is set (sticky).
- live and out_port never change while in PENDING, except on an accepted commit as above.
- Overflow clears only on a CTRL write with bit1=1. If set and clear occur in the same cycle, set wins.
- A CTRL write with bits 0 and 1 both set performs both actions.
- commit_count is 16-bit and wraps 0xFFFF -> 0x0000.
- out_ready is ignored in IDLE.

## Timing
- Reset (asynchronous assert, any time, including in PENDING):
  - all shadow, live, out_port = 0
  - out_valid = 0, overflow = 0, commit_count = 0, state IDLE
  - readdata then follows address with the zeroed registers
- A register write is visible on readdata and outputs the cycle after the write edge.
- readdata has zero-cycle latency (combinational on address and registers).
- Commit edge N: out_valid=1 and out_port=new values from cycle N+1.
- Handshake completes at the first edge where out_valid && out_ready. out_valid=0 the following cycle unless a commit was accepted on that edge.
- Back-to-back commits with out_ready held high sustain one vector per cycle.

## Test plan
- Reset then read all addresses -> every read 0, out_valid=0, out_port=0.
- CHANNELS=4, WIDTH=20; write shadow 0..3 = 0x12345, 0xFFFFF, 0x00001, 0xABCDE; read back; check out_port is unchanged (0). Commit -> next cycle out_valid=1 and out_port = {0xABCDE,0x00001,0xFFFFF,0x12345}; STATUS = 0x0001_0001.
- With out_ready=0 in PENDING, rewrite shadow 0 = 0x55555 and commit:
  - out_port unchanged, STATUS bit1=1, count stays 1.
  - Assert out_ready -> out_valid drops the next cycle.
  - CTRL write 0x2 -> overflow clears.
- Commit while out_ready=1 on a PENDING vector -> out_valid stays 1, live updates, count=2, no overflow.
- AUTO_COMMIT=1: write shadow 3 = 0x00F00 -> next cycle out_valid=1, live[3]=0x00F00. Write 32'hFFFF_FFFF to shadow 1 -> reads back 0x000FFFFF. Read unmapped address 15 -> 0.
- Assert reset_n=0 mid-PENDING -> out_valid, out_port, STATUS all 0 immediately. Preload count 0xFFFF via 65535 commits, commit once more -> count reads 0x0000.
